// File: rtl/fx_bus_pkg.sv
// Shared widths, FSM state encoding and request payload for the fx register bus arbiter.
package fx_bus_pkg;

    localparam int unsigned FX_AW      = 22;
    localparam int unsigned FX_DW      = 8;
    localparam int unsigned DEV_ID_MSB = 21;
    localparam int unsigned DEV_ID_LSB = 16;
    localparam int unsigned RD_CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RDW  = 2'd3
    } fx_arb_state_t;

    typedef struct packed {
        logic             we;
        logic [FX_AW-1:0] addr;
        logic [FX_DW-1:0] wdata;
    } fx_req_t;

endpackage

// File: rtl/fx_rr_arb2.sv
// Two-way round-robin picker; last_q records the most recently served master.
module fx_rr_arb2 (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       fixed_pri,
    output logic [1:0] gnt_c,
    output logic       last_q
);

    logic last_d;

    always_comb begin
        gnt_c  = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = (fixed_pri || last_q) ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
        endcase
        if (advance && (gnt_c != 2'b00)) begin
            last_d = gnt_c[1];
        end
    end

    // Reset value 1 makes master 0 the first tie winner.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fx_bus_arb.sv
// Two-master sequencer for the shared fx register bus: arbitrates, drives
// single-beat write/read strobes and routes the read return to its requester.
module fx_bus_arb
    import fx_bus_pkg::*;
#(
    parameter int unsigned RD_LAT    = 1,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [FX_AW-1:0] m0_addr,
    input  logic [FX_DW-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [FX_DW-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [FX_AW-1:0] m1_addr,
    input  logic [FX_DW-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [FX_DW-1:0] m1_rdata,
    output logic             fx_wr,
    output logic [FX_AW-1:0] fx_waddr,
    output logic [FX_DW-1:0] fx_data,
    output logic             fx_rd,
    output logic [FX_AW-1:0] fx_raddr,
    input  logic [FX_DW-1:0] fx_q
);

    fx_arb_state_t       state_q, state_d;
    logic [RD_CNT_W-1:0] cnt_q, cnt_d;
    logic                fx_wr_q, fx_wr_d, fx_rd_q, fx_rd_d;
    logic [FX_AW-1:0]    fx_waddr_q, fx_waddr_d, fx_raddr_q, fx_raddr_d;
    logic [FX_DW-1:0]    fx_data_q, fx_data_d;
    logic [1:0]          gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic [FX_DW-1:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    fx_req_t    req0_c, req1_c, sel_c;
    logic [1:0] arb_req_c, pick_c;
    logic       arb_en_c, rd_done_c, last_q;

    assign req0_c = {m0_we, m0_addr, m0_wdata};
    assign req1_c = {m1_we, m1_addr, m1_wdata};
    assign sel_c  = pick_c[1] ? req1_c : req0_c;

    assign rd_done_c = (state_q == RDW) && (cnt_q == RD_CNT_W'(RD_LAT));
    assign arb_en_c  = (state_q == IDLE) || (state_q == WR) || rd_done_c;
    // A request still high in its own gnt cycle belongs to the transaction just launched.
    assign arb_req_c = {m1_req, m0_req} & ~gnt_q;

    fx_rr_arb2 u_pick (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .req       (arb_req_c),
        .advance   (arb_en_c),
        .fixed_pri (FIXED_PRI),
        .gnt_c     (pick_c),
        .last_q    (last_q)
    );

    // Next state, bus launch and read-return routing; last_q names the read owner.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fx_wr_d    = 1'b0;
        fx_rd_d    = 1'b0;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        fx_waddr_d = fx_waddr_q;
        fx_data_d  = fx_data_q;
        fx_raddr_d = fx_raddr_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        case (state_q)
            RD: begin
                state_d = RDW;
                cnt_d   = RD_CNT_W'(1);
            end
            RDW: begin
                if (rd_done_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (last_q) begin
                        rvalid_d = 2'b10;
                        rdata1_d = fx_q;
                    end else begin
                        rvalid_d = 2'b01;
                        rdata0_d = fx_q;
                    end
                end else begin
                    cnt_d = cnt_q + RD_CNT_W'(1);
                end
            end
            default: state_d = state_q;
        endcase

        if (arb_en_c) begin
            state_d = IDLE;
            if (pick_c != 2'b00) begin
                gnt_d = pick_c;
                if (sel_c.we) begin
                    state_d    = WR;
                    fx_wr_d    = 1'b1;
                    fx_waddr_d = sel_c.addr;
                    fx_data_d  = sel_c.wdata;
                end else begin
                    state_d    = RD;
                    fx_rd_d    = 1'b1;
                    fx_raddr_d = sel_c.addr;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fx_wr_q    <= 1'b0;
            fx_rd_q    <= 1'b0;
            fx_waddr_q <= '0;
            fx_data_q  <= '0;
            fx_raddr_q <= '0;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fx_wr_q    <= fx_wr_d;
            fx_rd_q    <= fx_rd_d;
            fx_waddr_q <= fx_waddr_d;
            fx_data_q  <= fx_data_d;
            fx_raddr_q <= fx_raddr_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign fx_wr     = fx_wr_q;
    assign fx_rd     = fx_rd_q;
    assign fx_waddr  = fx_waddr_q;
    assign fx_data   = fx_data_q;
    assign fx_raddr  = fx_raddr_q;
    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_fx_bus_arb.sv
// Directed bench: instance a (RD_LAT=1, round-robin) and instance b (RD_LAT=3, fixed priority)
// share master stimulus; each has its own registered slave model on fx_q.
module tb_fx_bus_arb;

    logic        clk_sys, rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [21:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata;

    logic        m0_gnt_a, m0_rvalid_a, m1_gnt_a, m1_rvalid_a, fx_wr_a, fx_rd_a;
    logic [7:0]  m0_rdata_a, m1_rdata_a, fx_data_a, fxq_a;
    logic [21:0] fx_waddr_a, fx_raddr_a;
    logic        m0_gnt_b, m0_rvalid_b, m1_gnt_b, m1_rvalid_b, fx_wr_b, fx_rd_b;
    logic [7:0]  m0_rdata_b, m1_rdata_b, fx_data_b, fxq_b;
    logic [21:0] fx_waddr_b, fx_raddr_b;

    logic [7:0]  sa_val, sb_val;
    logic [1:0]  pb;
    int          n_vec, n_err;

    fx_bus_arb #(.RD_LAT(1), .FIXED_PRI(1'b0)) u_a (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt_a), .m0_rvalid(m0_rvalid_a), .m0_rdata(m0_rdata_a),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt_a), .m1_rvalid(m1_rvalid_a), .m1_rdata(m1_rdata_a),
        .fx_wr(fx_wr_a), .fx_waddr(fx_waddr_a), .fx_data(fx_data_a),
        .fx_rd(fx_rd_a), .fx_raddr(fx_raddr_a), .fx_q(fxq_a)
    );

    fx_bus_arb #(.RD_LAT(3), .FIXED_PRI(1'b1)) u_b (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt_b), .m0_rvalid(m0_rvalid_b), .m0_rdata(m0_rdata_b),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt_b), .m1_rvalid(m1_rvalid_b), .m1_rdata(m1_rdata_b),
        .fx_wr(fx_wr_b), .fx_waddr(fx_waddr_b), .fx_data(fx_data_b),
        .fx_rd(fx_rd_b), .fx_raddr(fx_raddr_b), .fx_q(fxq_b)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Slave models: return data RD_LAT cycles after fx_rd, zero otherwise.
    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fxq_a <= 8'h00;
            fxq_b <= 8'h00;
            pb    <= 2'b00;
        end else begin
            fxq_a <= fx_rd_a ? sa_val : 8'h00;
            pb    <= {pb[0], fx_rd_b};
            fxq_b <= pb[1] ? sb_val : 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        sa_val = 8'h00; sb_val = 8'h00;

        // Reset state
        tick();
        chk("rst_strobes", 32'({fx_wr_a, fx_rd_a, fx_wr_b, fx_rd_b}), 32'h0);
        chk("rst_gnt_rv", 32'({m0_gnt_a, m1_gnt_a, m0_rvalid_a, m1_rvalid_a}), 32'h0);
        chk("rst_waddr", 32'(fx_waddr_a), 32'h0);
        rst_n = 1'b1;
        tick();

        // m0 single write
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 22'h01_0020; m0_wdata = 8'hA5;
        tick();
        chk("wr_strobe", 32'({fx_wr_a, fx_rd_a}), 32'h2);
        chk("wr_addr", 32'(fx_waddr_a), 32'h01_0020);
        chk("wr_data", 32'(fx_data_a), 32'hA5);
        chk("wr_gnt", 32'({m1_gnt_a, m0_gnt_a}), 32'h1);
        m0_req = 1'b0;
        tick();
        chk("wr_one_cycle", 32'({fx_wr_a, m0_gnt_a}), 32'h0);
        chk("wr_addr_hold", 32'(fx_waddr_a), 32'h01_0020);

        // m1 read, RD_LAT=1
        sa_val = 8'h03;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 22'h01_0021;
        tick();
        chk("rd_strobe", 32'({fx_rd_a, fx_wr_a}), 32'h2);
        chk("rd_addr", 32'(fx_raddr_a), 32'h01_0021);
        chk("rd_gnt", 32'({m1_gnt_a, m0_gnt_a}), 32'h2);
        m1_req = 1'b0;
        tick();
        chk("rd_wait", 32'({fx_rd_a, fx_wr_a, m1_rvalid_a}), 32'h0);
        tick();
        chk("rd_rvalid", 32'({m1_rvalid_a, m0_rvalid_a}), 32'h2);
        chk("rd_rdata", 32'(m1_rdata_a), 32'h03);
        tick();
        chk("rd_rvalid_pulse", 32'(m1_rvalid_a), 32'h0);
        chk("rd_rdata_hold", 32'(m1_rdata_a), 32'h03);
        repeat (4) tick();

        // Continuous writes from both masters alternate, one per cycle
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 22'h02_0000; m0_wdata = 8'h10;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 22'h03_0000; m1_wdata = 8'h20;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_gnt", 32'({m1_gnt_a, m0_gnt_a}), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_wr", 32'({fx_wr_a, fx_rd_a}), 32'h2);
            chk("rr_addr", 32'(fx_waddr_a), (i % 2 == 0) ? 32'h02_0000 : 32'h03_0000);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) tick();

        // m0 read in flight, m1 write waits until the completion cycle
        sa_val = 8'h7E;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 22'h01_0030;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 22'h04_0001; m1_wdata = 8'h5A;
        tick();
        chk("rdwr_rd", 32'({fx_rd_a, fx_wr_a}), 32'h2);
        chk("rdwr_gnt0", 32'({m1_gnt_a, m0_gnt_a}), 32'h1);
        m0_req = 1'b0;
        tick();
        chk("rdwr_m1_waits", 32'({fx_wr_a, fx_rd_a, m1_gnt_a}), 32'h0);
        tick();
        chk("rdwr_rvalid", 32'({m0_rvalid_a, m0_rdata_a}), 32'h17E);
        chk("rdwr_wr_now", 32'({fx_wr_a, fx_rd_a, m1_gnt_a}), 32'h5);
        chk("rdwr_waddr", 32'({fx_waddr_a, fx_data_a}), 32'({22'h04_0001, 8'h5A}));
        m1_req = 1'b0;
        repeat (3) tick();

        // Reset asserted mid-read
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 22'h01_0040;
        tick();
        chk("mid_rd_launch", 32'(fx_rd_a), 32'h1);
        rst_n = 1'b0;
        m0_req = 1'b0;
        #1;
        chk("mid_rst_async", 32'({fx_rd_a, fx_wr_a, m0_gnt_a, m1_gnt_a, fx_rd_b, fx_wr_b}), 32'h0);
        chk("mid_rst_raddr", 32'(fx_raddr_a), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_rv", 32'({m0_rvalid_a, m1_rvalid_a, fx_rd_a}), 32'h0);
        end

        // Instance b, RD_LAT=3: m0 read to unmapped register
        sb_val = 8'h55;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 22'h3F_00FF;
        tick();
        chk("b_rd_strobe", 32'({fx_rd_b, m0_gnt_b}), 32'h3);
        chk("b_rd_addr", 32'(fx_raddr_b), 32'h3F_00FF);
        m0_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_rd_wait", 32'({fx_rd_b, fx_wr_b, m0_rvalid_b}), 32'h0);
        end
        tick();
        chk("b_rd_rvalid", 32'({m0_rvalid_b, m0_rdata_b}), 32'h155);
        repeat (2) tick();

        // Fixed priority: master 0 wins a tie even right after being served
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 22'h05_0000; m0_wdata = 8'h11;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 22'h06_0000; m1_wdata = 8'h22;
        tick();
        chk("b_fix_gnt", 32'({m1_gnt_b, m0_gnt_b}), 32'h1);
        chk("b_fix_addr", 32'(fx_waddr_b), 32'h05_0000);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) tick();

        // Request withdrawn before grant produces no transaction
        sb_val = 8'h66;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 22'h07_0002;
        tick();
        chk("b_wd_rd", 32'({fx_rd_b, m1_gnt_b}), 32'h3);
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 22'h08_0000; m0_wdata = 8'h99;
        tick();
        m0_req = 1'b0;
        repeat (2) tick();
        tick();
        chk("b_wd_rvalid", 32'({m1_rvalid_b, m1_rdata_b}), 32'h166);
        chk("b_wd_no_wr", 32'({fx_wr_b, m0_gnt_b}), 32'h0);
        tick();
        chk("b_wd_no_wr2", 32'({fx_wr_b, fx_rd_b, m0_gnt_b}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
